// File: rtl/apv_frame_emulator.sv
// apv_frame_emulator: synthetic APV25 ADC stream with periodic sync ticks and triggered header+sample frames
module apv_frame_emulator #(
  parameter int TRIG_QUEUE_MAX = 15,
  parameter int N_SAMPLES = 128
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        TRIGGER,
  input  logic [7:0]  SYNC_PERIOD,
  input  logic [11:0] LEVEL_HIGH,
  input  logic [11:0] LEVEL_LOW,
  input  logic [11:0] LEVEL_BASE,
  input  logic        RAMP_MODE,
  input  logic        ERROR_BIT,
  output logic [11:0] ADC_PDATA_OUT,
  output logic        FRAME_ACTIVE,
  output logic        TRIG_LOST,
  output logic [3:0]  PENDING,
  output logic [7:0]  FRAME_ADDR
);
  typedef enum logic [1:0] {IDLE, TICK, HEADER, DATA} state_t;
  state_t state;
  logic [7:0] cnt, idx;
  logic slot, start, cnt_run, hdr_bit, full;
  logic [11:0] sample;
  always_comb begin
    slot = cnt == 8'd0;
    start = state == TICK && ENABLE && slot && PENDING != 4'd0;
    cnt_run = (state == TICK && ENABLE) || state == HEADER || state == DATA;
    full = PENDING == 4'(TRIG_QUEUE_MAX);
    // header word 0 is emitted on the decision slot, so HEADER covers words 1..11
    hdr_bit = idx < 8'd3 ? 1'b1 : idx < 8'd11 ? FRAME_ADDR[3'd2 - idx[2:0]] : ERROR_BIT;
    sample = LEVEL_BASE + (RAMP_MODE ? {4'd0, idx} : 12'd0);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= 8'd0;
      idx <= 8'd0;
      PENDING <= 4'd0;
      FRAME_ADDR <= 8'd0;
      ADC_PDATA_OUT <= 12'd0;
      FRAME_ACTIVE <= 1'b0;
      TRIG_LOST <= 1'b0;
    end else begin
      cnt <= state == IDLE ? 8'd0 : !cnt_run ? cnt : slot ? SYNC_PERIOD : cnt - 8'd1;
      TRIG_LOST <= ENABLE && TRIGGER && !start && full;
      PENDING <= !ENABLE ? 4'd0 : start && !TRIGGER ? PENDING - 4'd1 :
                 TRIGGER && !start && !full ? PENDING + 4'd1 : PENDING;
      case (state)
        IDLE: begin
          ADC_PDATA_OUT <= LEVEL_LOW;
          FRAME_ACTIVE <= 1'b0;
          state <= ENABLE ? TICK : IDLE;
        end
        TICK: begin
          ADC_PDATA_OUT <= ENABLE && slot ? LEVEL_HIGH : LEVEL_LOW;
          FRAME_ACTIVE <= start;
          idx <= 8'd1;
          state <= !ENABLE ? IDLE : start ? HEADER : TICK;
        end
        HEADER: begin
          ADC_PDATA_OUT <= hdr_bit ? LEVEL_HIGH : LEVEL_LOW;
          FRAME_ACTIVE <= 1'b1;
          idx <= idx == 8'd11 ? 8'd0 : idx + 8'd1;
          state <= idx == 8'd11 ? DATA : HEADER;
        end
        DATA: begin
          ADC_PDATA_OUT <= sample;
          FRAME_ACTIVE <= 1'b1;
          idx <= idx + 8'd1;
          if (idx == 8'(N_SAMPLES - 1)) begin
            FRAME_ADDR <= FRAME_ADDR + 8'd1;
            state <= ENABLE ? TICK : IDLE;
          end
        end
      endcase
    end
  end
endmodule
